// File: rtl/uart_tx_arb_if.sv
// Bundles the requester byte streams and the TX FIFO write port of the UART transmit arbiter.
// Latency: none; this is a pure signal bundle.
// Backpressure: fifo_full gates req_ready of the granted requester; other requesters always see ready low.
interface uart_tx_arb_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic              fifo_full;
    logic              fifo_w_en;
    logic [7:0]        fifo_w_data;
    logic [1:0]        grant_id;
    logic              busy;

    // Requester/FIFO side: drives byte streams and the FIFO full flag.
    modport master (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_w_en, fifo_w_data, grant_id, busy
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_w_en, fifo_w_data, grant_id, busy
    );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin, packet-granular arbiter of NREQ byte streams onto the UART TX FIFO write port.
// Latency: 2 cycles from req_valid seen in IDLE to the first push; pushes then flow 1 byte/cycle.
// Backpressure: fifo_full drops req_ready combinationally; stalls never count toward the idle timeout.
// Optional: define UART_TX_ARB_PRIO_EN to give requester 0 strict priority at grant time.
module uart_tx_arb #(
    parameter int NREQ       = 2,
    parameter int MAX_BURST  = 8,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic         clk_tx,
    input  logic         rst_n,
    uart_tx_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GRANT, XFER, GAP} state_t;

    state_t     state;
    logic [1:0] rr_ptr;
    logic [1:0] grant_id_q;
    logic [7:0] beat_cnt;
    logic [7:0] tmo_cnt;
    logic [3:0] gap_cnt;

    logic       cur_valid;
    logic       cur_last;
    logic [7:0] cur_data;
    logic       xfer_rdy;
    logic       push;
    logic       grant_done;
    logic       pick_vld;
    logic [1:0] pick_id;
    int         scan_idx;

    // Mux out the granted requester's stream (compare loop keeps index widths exact for any NREQ).
    always_comb begin
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        cur_data  = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id_q == 2'(i)) begin
                cur_valid = bus.req_valid[i];
                cur_last  = bus.req_last[i];
                cur_data  = bus.req_data[8*i +: 8];
            end
        end
    end

    // Next-grant selection: nearest valid requester above rr_ptr, wrapping; scanned far-to-near so the nearest wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = 2'd0;
        scan_idx = 0;
        for (int k = NREQ; k >= 1; k--) begin
            scan_idx = int'(rr_ptr) + k;
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            if (bus.req_valid[scan_idx]) begin
                pick_vld = 1'b1;
                pick_id  = 2'(scan_idx);
            end
        end
`ifdef UART_TX_ARB_PRIO_EN
        if (bus.req_valid[0]) begin
            pick_vld = 1'b1;
            pick_id  = 2'd0;
        end
`else
`endif
    end

    // Push and release qualification for the current XFER cycle; last byte and burst cap share one release.
    always_comb begin
        xfer_rdy   = rst_n && (state == XFER) && !bus.fifo_full;
        push       = xfer_rdy && cur_valid;
        grant_done = (push && (cur_last || (beat_cnt == 8'(MAX_BURST - 1)))) ||
                     ((state == XFER) && !cur_valid && (tmo_cnt == 8'(TIMEOUT - 1)));
    end

    // Drive the FIFO port and per-requester ready; everything is forced low while reset is held.
    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_ready[i] = xfer_rdy && (grant_id_q == 2'(i));
        end
        bus.fifo_w_en   = push;
        bus.fifo_w_data = push ? cur_data : 8'h00;
        bus.grant_id    = grant_id_q;
        bus.busy        = rst_n && (state != IDLE);
    end

    // Arbiter FSM with grant, burst, timeout and gap bookkeeping.
    always_ff @(posedge clk_tx) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= 2'(NREQ - 1);
            grant_id_q <= 2'd0;
            beat_cnt   <= 8'd0;
            tmo_cnt    <= 8'd0;
            gap_cnt    <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant_id_q <= pick_id;
                        state      <= GRANT;
                    end
                end
                GRANT: begin
                    beat_cnt <= 8'd0;
                    tmo_cnt  <= 8'd0;
                    state    <= XFER;
                end
                XFER: begin
                    if (push) begin
                        beat_cnt <= beat_cnt + 8'd1;
                    end
                    tmo_cnt <= cur_valid ? 8'd0 : tmo_cnt + 8'd1;
                    if (grant_done) begin
                        rr_ptr  <= grant_id_q;
                        gap_cnt <= 4'd0;
                        state   <= (GAP_CYCLES > 0) ? GAP : IDLE;
                    end
                end
                GAP: begin
                    if (gap_cnt == 4'(GAP_CYCLES - 1)) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: directed vector table, corner-case sequences, random traffic vs. a timer-based model.
// Latency: outputs sampled on the falling edge after inputs are applied just past the rising edge.
// Backpressure: fifo_full is driven directly, both in directed windows and randomly.
module tb_uart_tx_arb;
    localparam int NREQ       = 2;
    localparam int MAX_BURST  = 4;
    localparam int GAP_CYCLES = 2;
    localparam int TIMEOUT    = 16;

    logic clk_tx;
    logic rst_n;

    uart_tx_arb_if #(.NREQ(NREQ)) bus ();

    uart_tx_arb #(
        .NREQ(NREQ), .MAX_BURST(MAX_BURST), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_tx(clk_tx),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk_tx = 1'b0;
    always #5 clk_tx = ~clk_tx;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int push_cyc[$];
    int push_gid[$];
    int push_dat[$];

    // Reference model: who owns the port, how long until it may push, gap cooldown remaining.
    int m_owner;
    int m_pend;
    int m_cool;
    int m_sent;
    int m_quiet;
    int m_gid;
    int m_lastrel;

    typedef struct packed {
        logic       rst;
        logic [1:0] v;
        logic [15:0] d;
        logic [1:0] l;
        logic       f;
        logic [1:0] e_rdy;
        logic       e_wen;
        logic [7:0] e_dat;
        logic [1:0] e_gid;
        logic       e_busy;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_pend    = 0;
        m_cool    = 0;
        m_sent    = 0;
        m_quiet   = 0;
        m_gid     = 0;
        m_lastrel = NREQ - 1;
    endtask

    function automatic int pick(input logic [1:0] v);
`ifdef UART_TX_ARB_PRIO_EN
        if (v[0]) return 0;
`else
`endif
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (m_lastrel + k) % NREQ;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    // One clock: apply inputs, compare every output with the model, log pushes, advance the model.
    task automatic step(input logic [1:0] v, input logic [15:0] d, input logic [1:0] l,
                        input logic f, input logic r);
        logic [1:0] e_rdy;
        logic       e_wen;
        logic [7:0] e_dat;
        logic       e_busy;
        logic       rel;
        @(posedge clk_tx);
        #1;
        bus.req_valid = v;
        bus.req_data  = d;
        bus.req_last  = l;
        bus.fifo_full = f;
        rst_n         = r;
        @(negedge clk_tx);
        cyc++;
        e_rdy  = 2'b00;
        e_wen  = 1'b0;
        e_dat  = 8'h00;
        e_busy = 1'b0;
        if (r) begin
            e_busy = (m_owner >= 0) || (m_cool > 0);
            if (m_owner >= 0 && m_pend == 0 && !f) begin
                e_rdy = 2'(1 << m_owner);
                e_wen = v[m_owner];
                if (e_wen) e_dat = d[8*m_owner +: 8];
            end
        end
        check($sformatf("model_c%0d", cyc),
              {18'd0, bus.req_ready, bus.fifo_w_en, bus.fifo_w_data, bus.grant_id, bus.busy},
              {18'd0, e_rdy, e_wen, e_dat, 2'(m_gid), e_busy});
        if (bus.fifo_w_en) begin
            push_cyc.push_back(cyc);
            push_gid.push_back(int'(bus.grant_id));
            push_dat.push_back(int'(bus.fifo_w_data));
        end
        if (!r) begin
            model_reset();
        end else if (m_owner < 0 && m_cool == 0) begin
            if (v != 2'b00) begin
                m_owner = pick(v);
                m_gid   = m_owner;
                m_pend  = 1;
            end
        end else if (m_owner >= 0 && m_pend > 0) begin
            m_pend  = 0;
            m_sent  = 0;
            m_quiet = 0;
        end else if (m_owner >= 0) begin
            rel = 1'b0;
            if (e_wen) begin
                m_sent++;
                if (l[m_owner] || m_sent == MAX_BURST) rel = 1'b1;
            end else if (!v[m_owner] && m_quiet == TIMEOUT - 1) begin
                rel = 1'b1;
            end
            m_quiet = v[m_owner] ? 0 : m_quiet + 1;
            if (rel) begin
                m_lastrel = m_owner;
                m_owner   = -1;
                m_cool    = GAP_CYCLES;
            end
        end else begin
            m_cool--;
        end
    endtask

    task automatic clear_log();
        push_cyc.delete();
        push_gid.delete();
        push_dat.delete();
    endtask

    task automatic go_idle();
        int n;
        n = 0;
        step(2'b00, 16'h0000, 2'b00, 1'b0, 1'b1);
        while (bus.busy && n < 40) begin
            step(2'b00, 16'h0000, 2'b00, 1'b0, 1'b1);
            n++;
        end
        check("drain_busy", {31'd0, bus.busy}, 32'd0);
        clear_log();
    endtask

    vec_t tbl[21];

    initial begin
        vec_t t;
        logic [7:0] b;
        logic [7:0] bp_byte;
        int n_push;
        int full_left;
        bit got0;
        logic [1:0] rv;
        logic [1:0] rl;

        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.fifo_full = 1'b0;
        model_reset();

        //            rst  v      d          l      f     rdy    wen   dat    gid   busy
        tbl[0]  = '{1'b0, 2'b11, 16'h0000, 2'b00, 1'b0, 2'b00, 1'b0, 8'h00, 2'd0, 1'b0};
        tbl[1]  = '{1'b1, 2'b00, 16'h0000, 2'b00, 1'b0, 2'b00, 1'b0, 8'h00, 2'd0, 1'b0};
        tbl[2]  = '{1'b1, 2'b10, 16'h1100, 2'b00, 1'b0, 2'b00, 1'b0, 8'h00, 2'd0, 1'b0};
        tbl[3]  = '{1'b1, 2'b10, 16'h1100, 2'b00, 1'b0, 2'b00, 1'b0, 8'h00, 2'd1, 1'b1};
        tbl[4]  = '{1'b1, 2'b10, 16'h1100, 2'b00, 1'b0, 2'b10, 1'b1, 8'h11, 2'd1, 1'b1};
        tbl[5]  = '{1'b1, 2'b10, 16'h2200, 2'b00, 1'b0, 2'b10, 1'b1, 8'h22, 2'd1, 1'b1};
        tbl[6]  = '{1'b1, 2'b10, 16'h3300, 2'b10, 1'b0, 2'b10, 1'b1, 8'h33, 2'd1, 1'b1};
        tbl[7]  = '{1'b1, 2'b00, 16'h0000, 2'b00, 1'b0, 2'b00, 1'b0, 8'h00, 2'd1, 1'b1};
        tbl[8]  = '{1'b1, 2'b00, 16'h0000, 2'b00, 1'b0, 2'b00, 1'b0, 8'h00, 2'd1, 1'b1};
        tbl[9]  = '{1'b1, 2'b00, 16'h0000, 2'b00, 1'b0, 2'b00, 1'b0, 8'h00, 2'd1, 1'b0};
        tbl[10] = '{1'b1, 2'b10, 16'hAA00, 2'b00, 1'b0, 2'b00, 1'b0, 8'h00, 2'd1, 1'b0};
        tbl[11] = '{1'b1, 2'b10, 16'hAA00, 2'b00, 1'b0, 2'b00, 1'b0, 8'h00, 2'd1, 1'b1};
        tbl[12] = '{1'b1, 2'b10, 16'hAA00, 2'b00, 1'b0, 2'b10, 1'b1, 8'hAA, 2'd1, 1'b1};
        tbl[13] = '{1'b0, 2'b10, 16'hBB00, 2'b00, 1'b0, 2'b00, 1'b0, 8'h00, 2'd1, 1'b0};
        tbl[14] = '{1'b1, 2'b00, 16'h0000, 2'b00, 1'b0, 2'b00, 1'b0, 8'h00, 2'd0, 1'b0};
        tbl[15] = '{1'b1, 2'b10, 16'hCC00, 2'b10, 1'b0, 2'b00, 1'b0, 8'h00, 2'd0, 1'b0};
        tbl[16] = '{1'b1, 2'b10, 16'hCC00, 2'b10, 1'b0, 2'b00, 1'b0, 8'h00, 2'd1, 1'b1};
        tbl[17] = '{1'b1, 2'b10, 16'hCC00, 2'b10, 1'b0, 2'b10, 1'b1, 8'hCC, 2'd1, 1'b1};
        tbl[18] = '{1'b1, 2'b00, 16'h0000, 2'b00, 1'b0, 2'b00, 1'b0, 8'h00, 2'd1, 1'b1};
        tbl[19] = '{1'b1, 2'b00, 16'h0000, 2'b00, 1'b0, 2'b00, 1'b0, 8'h00, 2'd1, 1'b1};
        tbl[20] = '{1'b1, 2'b00, 16'h0000, 2'b00, 1'b0, 2'b00, 1'b0, 8'h00, 2'd1, 1'b0};

        // Reset state, single-requester packet with 2-cycle latency and gap, reset mid-XFER.
        for (int i = 0; i < 21; i++) begin
            t = tbl[i];
            step(t.v, t.d, t.l, t.f, t.rst);
            check($sformatf("tbl%0d_rdy", i),  {30'd0, bus.req_ready},  {30'd0, t.e_rdy});
            check($sformatf("tbl%0d_wen", i),  {31'd0, bus.fifo_w_en},  {31'd0, t.e_wen});
            check($sformatf("tbl%0d_dat", i),  {24'd0, bus.fifo_w_data}, {24'd0, t.e_dat});
            check($sformatf("tbl%0d_gid", i),  {30'd0, bus.grant_id},   {30'd0, t.e_gid});
            check($sformatf("tbl%0d_busy", i), {31'd0, bus.busy},       {31'd0, t.e_busy});
        end

        // Contention: both requesters always valid with 1-byte packets.
        go_idle();
        for (int c = 0; c < 25; c++) begin
            step(2'b11, 16'($urandom), 2'b11, 1'b0, 1'b1);
        end
        check("cont_count", {31'd0, push_cyc.size() >= 4}, 32'd1);
        if (push_cyc.size() >= 4) begin
            for (int k = 0; k < 4; k++) begin
`ifdef UART_TX_ARB_PRIO_EN
                check($sformatf("cont_gid%0d", k), push_gid[k], 0);
`else
                check($sformatf("cont_gid%0d", k), push_gid[k], k % 2);
`endif
                if (k > 0) check($sformatf("cont_gap%0d", k), push_cyc[k] - push_cyc[k-1], 5);
            end
        end

        // Burst limit: req 0 streams with no last; variant 0 alone, variant 1 with req 1 joining.
        for (int variant = 0; variant < 2; variant++) begin
            go_idle();
            b = 8'd0;
            for (int c = 0; c < 16; c++) begin
                step((variant == 1 && c >= 2) ? 2'b11 : 2'b01, {8'h5A, b}, 2'b10, 1'b0, 1'b1);
                if (bus.fifo_w_en && bus.req_ready[0]) b = b + 8'd1;
            end
            check($sformatf("burst%0d_count", variant), {31'd0, push_cyc.size() >= 5}, 32'd1);
            if (push_cyc.size() >= 5) begin
                for (int k = 0; k < 4; k++) begin
                    check($sformatf("burst%0d_dat%0d", variant, k), push_dat[k], k);
                    check($sformatf("burst%0d_gid%0d", variant, k), push_gid[k], 0);
                end
                check($sformatf("burst%0d_run", variant), push_cyc[3] - push_cyc[0], 3);
                check($sformatf("burst%0d_regap", variant), push_cyc[4] - push_cyc[3], 5);
`ifdef UART_TX_ARB_PRIO_EN
                check($sformatf("burst%0d_next", variant), push_gid[4], 0);
`else
                check($sformatf("burst%0d_next", variant), push_gid[4], variant);
`endif
            end
        end

        // Backpressure: fifo_full held 5 cycles after the 2nd byte of a 4-byte packet.
        go_idle();
        n_push    = 0;
        full_left = 0;
        for (int c = 0; c < 24; c++) begin
            bp_byte = 8'(8'hB0 + n_push);
            step((n_push < 4) ? 2'b10 : 2'b00, {bp_byte, 8'h00},
                 (n_push == 3) ? 2'b10 : 2'b00, full_left > 0, 1'b1);
            if (full_left > 0) begin
                check("bp_ready", {30'd0, bus.req_ready}, 32'd0);
                check("bp_wen", {31'd0, bus.fifo_w_en}, 32'd0);
                full_left--;
            end
            if (bus.fifo_w_en) begin
                n_push++;
                if (n_push == 2) full_left = 5;
            end
        end
        check("bp_count", push_cyc.size(), 4);
        if (push_cyc.size() == 4) begin
            for (int k = 0; k < 4; k++) check($sformatf("bp_dat%0d", k), push_dat[k], 8'hB0 + k);
            check("bp_stall", push_cyc[2] - push_cyc[1], 6);
            check("bp_resume", push_cyc[3] - push_cyc[2], 1);
        end

        // Timeout: req 0 sends one byte then goes quiet; req 1 waits.
        go_idle();
        got0 = 1'b0;
        for (int c = 0; c < 45; c++) begin
            step(got0 ? 2'b10 : 2'b01, 16'h9977, got0 ? 2'b10 : 2'b00, 1'b0, 1'b1);
            if (bus.fifo_w_en) got0 = 1'b1;
            if (push_cyc.size() >= 2) break;
        end
        check("tmo_count", {31'd0, push_cyc.size() >= 2}, 32'd1);
        if (push_cyc.size() >= 2) begin
            check("tmo_gid0", push_gid[0], 0);
            check("tmo_gid1", push_gid[1], 1);
            check("tmo_delay", push_cyc[1] - push_cyc[0], 21);
        end

        // Random traffic, backpressure and occasional resets against the model.
        go_idle();
        for (int i = 0; i < 3000; i++) begin
            rv[0] = ($urandom_range(0, 3) != 0);
            rv[1] = ($urandom_range(0, 3) != 0);
            rl[0] = ($urandom_range(0, 3) == 0);
            rl[1] = ($urandom_range(0, 3) == 0);
            step(rv, 16'($urandom), rl, $urandom_range(0, 4) == 0, $urandom_range(0, 199) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
